// File: rtl/ro_touch_detector_pkg.sv
// Shared types, default constants and the widened threshold compare for the
// ring-oscillator touch detector.
package ro_pkg;

  typedef enum logic [1:0] {
    WARMUP = 2'd0,
    SEED   = 2'd1,
    RUN    = 2'd2
  } ro_state_e;

  localparam int unsigned RO_GATE_CYCLES = 65536;
  localparam int unsigned RO_CNT_W       = 20;
  localparam int unsigned RO_THRESH      = 5;
  localparam int unsigned RO_DEBOUNCE    = 7;
  localparam int unsigned RO_AVG_SHIFT   = 3;

  // (value + thresh) < base, evaluated wide enough that the sum cannot wrap
  function automatic logic drop_below(input logic [63:0] value,
                                      input logic [63:0] thresh,
                                      input logic [63:0] base);
    return (value + thresh) < base;
  endfunction

endpackage

// File: rtl/ro_edge_counter.sv
// Synchronises the divided oscillator, detects rising edges and counts them
// per fixed CLK window; result includes the current cycle's edge.
module ro_edge_counter
  import ro_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = RO_GATE_CYCLES,
  parameter int unsigned CNT_W       = RO_CNT_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             osc_in,
  output logic [CNT_W-1:0] result,
  output logic             window_done
);

  localparam int unsigned      WIN_W    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic             sync1, sync2, hist;
  logic             edge_det;
  logic [WIN_W-1:0] win_cnt;
  logic [CNT_W-1:0] edge_cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist  <= 1'b0;
    end else begin
      sync1 <= osc_in;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  assign edge_det    = sync2 & ~hist;
  assign window_done = (win_cnt == WIN_LAST);
  // Saturate rather than wrap so a runaway oscillator never reads as a drop
  assign result      = (edge_det && (edge_cnt != CNT_MAX)) ? edge_cnt + CNT_W'(1) : edge_cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      win_cnt  <= '0;
      edge_cnt <= '0;
    end else if (window_done) begin
      win_cnt  <= '0;
      edge_cnt <= '0;
    end else begin
      win_cnt  <= win_cnt + WIN_W'(1);
      edge_cnt <= result;
    end
  end

endmodule

// File: rtl/ro_touch_detector.sv
// Per-window oscillator counts, slow IIR baseline and debounced touch flag.
// All state advances only at window end; outputs update with count_valid.
module ro_touch_detector
  import ro_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = RO_GATE_CYCLES,
  parameter int unsigned CNT_W       = RO_CNT_W,
  parameter int unsigned THRESH      = RO_THRESH,
  parameter int unsigned DEBOUNCE    = RO_DEBOUNCE,
  parameter int unsigned AVG_SHIFT   = RO_AVG_SHIFT
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             osc_in,
  output logic [CNT_W-1:0] count_out,
  output logic             count_valid,
  output logic [CNT_W-1:0] baseline_out,
  output logic             touch,
  output logic             touch_event
);

  localparam int unsigned      DBC_W    = $clog2(DEBOUNCE + 1);
  localparam logic [DBC_W-1:0] DBC_LOAD = DBC_W'(DEBOUNCE);

  ro_state_e          state_q, state_d;
  logic [CNT_W-1:0]   result;
  logic               window_done;
  logic               below;
  logic [CNT_W-1:0]   baseline_d;
  logic               touch_d, touch_event_d;
  logic [DBC_W-1:0]   dbc_q, dbc_d;
  logic signed [CNT_W:0] diff, adj;

  ro_edge_counter #(
    .GATE_CYCLES (GATE_CYCLES),
    .CNT_W       (CNT_W)
  ) u_edge_counter (
    .CLK         (CLK),
    .RST         (RST),
    .osc_in      (osc_in),
    .result      (result),
    .window_done (window_done)
  );

  always_comb begin
    state_d       = state_q;
    baseline_d    = baseline_out;
    touch_d       = touch;
    touch_event_d = 1'b0;
    dbc_d         = dbc_q;
    diff          = $signed({1'b0, result}) - $signed({1'b0, baseline_out});
    adj           = diff >>> AVG_SHIFT;
    below         = drop_below(64'(result), 64'(THRESH), 64'(baseline_out));
    if (window_done) begin
      unique case (state_q)
        WARMUP: state_d = SEED;
        SEED: begin
          baseline_d = result;
          state_d    = RUN;
        end
        RUN: begin
          if (below) begin
            touch_d       = 1'b1;
            touch_event_d = ~touch;
            dbc_d         = DBC_LOAD;
          end else if (touch) begin
            // Baseline stays frozen through the whole release, including the final window
            if (dbc_q != '0) dbc_d = dbc_q - DBC_W'(1);
            else             touch_d = 1'b0;
          end else begin
            baseline_d = baseline_out + CNT_W'(adj);
          end
        end
        default: state_d = WARMUP;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= WARMUP;
      count_out    <= '0;
      count_valid  <= 1'b0;
      baseline_out <= '0;
      touch        <= 1'b0;
      touch_event  <= 1'b0;
      dbc_q        <= '0;
    end else begin
      state_q      <= state_d;
      count_valid  <= window_done;
      if (window_done) count_out <= result;
      baseline_out <= baseline_d;
      touch        <= touch_d;
      touch_event  <= touch_event_d;
      dbc_q        <= dbc_d;
    end
  end

endmodule

// File: tb/tb_ro_touch_detector.sv
// Bench for ro_touch_detector: window table, reset-mid-window sequence and
// randomized oscillator periods against a window-level reference model.
module tb_ro_touch_detector;

  localparam int G = 100, W = 8, W4 = 4, TH = 5, DEB = 2, SH = 2;

  logic CLK = 1'b0, RST = 1'b1, osc_in = 1'b0;
  logic [W-1:0]  count_out, baseline_out;
  logic          count_valid, touch, touch_event;
  logic [W4-1:0] count_out4, baseline_out4;
  logic          count_valid4, touch4, touch_event4;

  ro_touch_detector #(.GATE_CYCLES(G), .CNT_W(W), .THRESH(TH), .DEBOUNCE(DEB), .AVG_SHIFT(SH)) dut (
    .CLK(CLK), .RST(RST), .osc_in(osc_in), .count_out(count_out), .count_valid(count_valid),
    .baseline_out(baseline_out), .touch(touch), .touch_event(touch_event));

  ro_touch_detector #(.GATE_CYCLES(G), .CNT_W(W4), .THRESH(TH), .DEBOUNCE(DEB), .AVG_SHIFT(SH)) dut4 (
    .CLK(CLK), .RST(RST), .osc_in(osc_in), .count_out(count_out4), .count_valid(count_valid4),
    .baseline_out(baseline_out4), .touch(touch4), .touch_event(touch_event4));

  always #5 CLK = ~CLK;

  int vectors = 0, errors = 0;
  int gt = 0;

  // Reference model: o history, raw (unsaturated) edge total, window phase
  int m_pos, m_raw, m_phase, m_base, m_nb;
  bit m_touch;
  bit [2:0] m_o;
  int e_cnt, e_cnt4;
  bit e_cv, e_ev;

  typedef struct { int period; int cnt; int base; bit tch; bit ev; } row_t;
  row_t tbl[$];

  function automatic int sat(input int v, input int w);
    return (v > (1 << w) - 1) ? (1 << w) - 1 : v;
  endfunction

  function automatic bit osc_val(input int p, input int t);
    return (p == 0) ? 1'b0 : ((t % p) < p / 2);
  endfunction

  task automatic model_tick(input bit r, input bit o);
    int res;
    e_cv = 1'b0;
    e_ev = 1'b0;
    if (r) begin
      m_pos = 0; m_raw = 0; m_phase = 0; m_base = 0; m_nb = 0;
      m_touch = 1'b0; m_o = '0; e_cnt = 0; e_cnt4 = 0;
    end else begin
      // an edge reaches the counter three samples after it appears on osc_in
      if (m_o[1] && !m_o[2]) m_raw++;
      m_o = {m_o[1:0], o};
      if (m_pos == G - 1) begin
        res    = sat(m_raw, W);
        e_cnt  = res;
        e_cnt4 = sat(m_raw, W4);
        e_cv   = 1'b1;
        m_raw  = 0;
        m_pos  = 0;
        if (m_phase == 0) m_phase = 1;
        else if (m_phase == 1) begin
          m_base  = res;
          m_phase = 2;
        end else if (res + TH < m_base) begin
          e_ev    = !m_touch;
          m_touch = 1'b1;
          m_nb    = 0;
        end else if (m_touch) begin
          m_nb++;
          if (m_nb > DEB) begin
            m_touch = 1'b0;
            m_nb    = 0;
          end
        end else begin
          m_base = m_base + ((res - m_base) >>> SH);
        end
      end else begin
        m_pos++;
      end
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_model();
    chk("model", 64'({count_out, count_valid, baseline_out, touch, touch_event, count_out4, count_valid4}),
        64'({8'(e_cnt), e_cv, 8'(m_base), m_touch, e_ev, 4'(e_cnt4), e_cv}));
  endtask

  task automatic step(input bit r, input bit o);
    RST    = r;
    osc_in = o;
    @(posedge CLK);
    model_tick(r, o);
    gt++;
    @(negedge CLK);
    chk_model();
  endtask

  task automatic run_win(input int p);
    repeat (G) step(1'b0, osc_val(p, m_pos));
  endtask

  task automatic add(input int p, input int c, input int b, input bit t, input bit e);
    row_t r;
    r.period = p; r.cnt = c; r.base = b; r.tch = t; r.ev = e;
    tbl.push_back(r);
  endtask

  initial begin
    int cv_seen;
    add(4, 25, 0, 0, 0);   add(4, 25, 25, 0, 0);  add(4, 25, 25, 0, 0);
    add(5, 20, 23, 0, 0);  add(4, 25, 23, 0, 0);  add(10, 10, 23, 1, 1);
    add(10, 10, 23, 1, 0); add(4, 25, 23, 1, 0);  add(4, 25, 23, 1, 0);
    add(10, 10, 23, 1, 0); add(4, 25, 23, 1, 0);  add(4, 25, 23, 1, 0);
    add(4, 25, 23, 0, 0);  add(4, 25, 23, 0, 0);  add(0, 0, 23, 1, 1);
    add(50, 2, 23, 1, 0);  add(20, 5, 23, 1, 0);  add(4, 25, 23, 1, 0);
    add(4, 25, 23, 1, 0);  add(4, 25, 23, 0, 0);  add(5, 20, 22, 0, 0);
    add(5, 20, 21, 0, 0);  add(5, 20, 20, 0, 0);  add(5, 20, 20, 0, 0);
    add(4, 25, 21, 0, 0);

    @(negedge CLK);
    repeat (3) step(1'b1, 1'b0);
    chk("reset", 64'({count_out, count_valid, baseline_out, touch, touch_event}), 64'(0));

    for (int i = 0; i < tbl.size(); i++) begin
      run_win(tbl[i].period);
      chk($sformatf("w%0d valid", i + 1), 64'(count_valid), 64'(1));
      chk($sformatf("w%0d count", i + 1), 64'(count_out), 64'(tbl[i].cnt));
      chk($sformatf("w%0d baseline", i + 1), 64'(baseline_out), 64'(tbl[i].base));
      chk($sformatf("w%0d touch", i + 1), 64'(touch), 64'(tbl[i].tch));
      chk($sformatf("w%0d event", i + 1), 64'(touch_event), 64'(tbl[i].ev));
      if (i == 0) chk("sat4 count", 64'(count_out4), 64'(15));
    end

    // Reset mid-window while touched: partial count lost, FSM re-seeds
    run_win(10);
    chk("pre-reset touch", 64'(touch), 64'(1));
    for (int t = 0; t < 50; t++) step(1'b0, osc_val(4, t));
    step(1'b1, 1'b0);
    chk("mid reset", 64'({count_out, count_valid, baseline_out, touch, touch_event}), 64'(0));
    cv_seen = 0;
    for (int t = 0; t < G - 1; t++) begin
      step(1'b0, osc_val(4, t));
      if (count_valid) cv_seen++;
    end
    chk("no early valid", 64'(cv_seen), 64'(0));
    step(1'b0, osc_val(4, G - 1));
    chk("first valid after reset", 64'({count_valid, count_out, baseline_out, touch}), 64'({1'b1, 8'd25, 8'd0, 1'b0}));
    run_win(4);
    chk("reseed baseline", 64'(baseline_out), 64'(25));

    // Randomized periods and phases, occasional resets anywhere in a window
    for (int w = 0; w < 40; w++) begin
      int p, ph, rst_at;
      case ($urandom_range(0, 7))
        0: p = 0;  1: p = 4;  2: p = 5;  3: p = 6;
        4: p = 7;  5: p = 8;  6: p = 10; default: p = 13;
      endcase
      ph     = $urandom_range(0, 12);
      rst_at = ($urandom_range(0, 9) == 0) ? $urandom_range(0, G - 1) : -1;
      for (int t = 0; t < G; t++) step(t == rst_at, osc_val(p, gt + ph));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
